// File: rtl/ksa_pipe_if.sv
// Operand/result handshake bundle for ksa_pipe.
// The Ovf signal exists only when KSA_PIPE_OVF_EN is defined.
interface ksa_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         Cout;
`ifdef KSA_PIPE_OVF_EN
  logic         Ovf;

  modport master (
    output in_valid, A, B, Cin, op_sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );
  modport slave (
    input  in_valid, A, B, Cin, op_sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
`else
  modport master (
    output in_valid, A, B, Cin, op_sub, out_ready,
    input  in_ready, out_valid, Sum, Cout
  );
  modport slave (
    input  in_valid, A, B, Cin, op_sub, out_ready,
    output in_ready, out_valid, Sum, Cout
  );
`endif
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control per stage.
// Define KSA_PIPE_OVF_EN to add the registered signed-overflow output Ovf.
module ksa_pipe #(
  parameter int                WIDIDX    = 3,
  parameter logic [WIDIDX-1:0] PIPE_REGS = '0
) (
  input logic       clk,
  input logic       rst_n,
  ksa_pipe_if.slave bus
);
  localparam int N = 2**WIDIDX;
  // Level WIDIDX never gets an internal register: the output register follows it.
  localparam logic [WIDIDX:0] REG_MASK = {1'b0, PIPE_REGS};

  logic out_rdy;

  // Level 0 forms P/G with carry-in folded into bit 0; levels 1..WIDIDX combine spans 2**(k-1).
  for (genvar k = 0; k <= WIDIDX; k++) begin : lvl
    logic [N-1:0] a_g, a_pg, a_p;
    logic         a_c, a_v;
    logic [N-1:0] y_g, y_pg;
    logic [N-1:0] o_g, o_pg, o_p;
    logic         o_c, o_v;
    logic         rdy_i, rdy_o;

    if (k == 0) begin : gen_pg
      logic [N-1:0] b_eff;
      assign b_eff = bus.op_sub ? ~bus.B : bus.B;
      assign a_c   = bus.Cin ^ bus.op_sub;
      assign a_v   = bus.in_valid;
      assign a_g   = bus.A & b_eff;
      assign a_pg  = bus.A ^ b_eff;
      assign a_p   = a_pg;
      assign y_pg  = a_pg;
      assign y_g   = {a_g[N-1:1], a_g[0] | (a_pg[0] & a_c)};
    end else begin : gen_pre
      localparam int S = 2**(k-1);
      assign a_g  = lvl[k-1].o_g;
      assign a_pg = lvl[k-1].o_pg;
      assign a_p  = lvl[k-1].o_p;
      assign a_c  = lvl[k-1].o_c;
      assign a_v  = lvl[k-1].o_v;

      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      always_comb begin
        y_g  = a_g;
        y_pg = a_pg;
        for (int j = S; j < N; j++) begin
          y_g[j]  = a_g[j] | (a_pg[j] & a_g[j-S]);
          y_pg[j] = a_pg[j] & a_pg[j-S];
        end
      end
    end

    if (k == WIDIDX) begin : gen_rdy_last
      assign rdy_o = out_rdy;
    end else begin : gen_rdy_mid
      assign rdy_o = lvl[k+1].rdy_i;
    end

    if (REG_MASK[k]) begin : gen_reg
      assign rdy_i = ~o_v | rdy_o;

      // NOTE: clocked state uses <= so each stage samples its neighbour's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     o_v <= 1'b0;
        else if (rdy_i) o_v <= a_v;
      end

      // NOTE: stage data has no reset; o_v alone qualifies it, so only the valid bit is cleared.
      always_ff @(posedge clk) begin
        if (rdy_i && a_v) begin
          o_g  <= y_g;
          o_pg <= y_pg;
          o_p  <= a_p;
          o_c  <= a_c;
        end
      end
    end else begin : gen_thru
      assign rdy_i = rdy_o;
      assign o_v   = a_v;
      assign o_g   = y_g;
      assign o_pg  = y_pg;
      assign o_p   = a_p;
      assign o_c   = a_c;
    end
  end

  logic [N-1:0] fin_g, fin_p, carry;
  logic         fin_c, fin_v;
  logic         unused_pg;

  assign fin_g     = lvl[WIDIDX].o_g;
  assign fin_p     = lvl[WIDIDX].o_p;
  assign fin_c     = lvl[WIDIDX].o_c;
  assign fin_v     = lvl[WIDIDX].o_v;
  // The final group-propagate vector has no consumer.
  assign unused_pg = ^lvl[WIDIDX].o_pg;

  // After the last level, fin_g[j] is the carry out of bit j.
  assign carry = {fin_g[N-2:0], fin_c};

  logic         out_valid_q;
  logic [N-1:0] sum_q;
  logic         cout_q;

  assign out_rdy      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = lvl[0].rdy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (out_rdy) begin
      out_valid_q <= fin_v;
      if (fin_v) begin
        sum_q  <= fin_p ^ carry;
        cout_q <= fin_g[N-1];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;

`ifdef KSA_PIPE_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf_q <= 1'b0;
    else if (out_rdy && fin_v)  ovf_q <= fin_g[N-1] ^ carry[N-1];
  end

  assign bus.Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ksa_pipe.sv
// Directed bench for ksa_pipe with WIDIDX=3, PIPE_REGS=3'b101 (latency 3).
// Ovf checks are compiled in only when KSA_PIPE_OVF_EN is defined.
module tb_ksa_pipe;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [9:0] exp;   // {ovf, cout, sum}
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ksa_pipe_if #(.N(8)) bus ();

  ksa_pipe #(.WIDIDX(3), .PIPE_REGS(3'b101)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         total   = 0;
  int         bad     = 0;
  int         cyc     = 0;
  int         acc_cyc = 0;
  logic       or_next = 1'b1;
  beat_t      pend_q[$];
  logic [9:0] exp_q[$];
  int         out_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ovf;
    bb  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, bb} + {8'd0, sub ? ~cin : cin};
    ovf = (a[7] == bb[7]) && (r[7] != a[7]);
    return {ovf, r};
  endfunction

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [9:0] exp);
    beat_t bt;
    bt.a = a; bt.b = b; bt.cin = cin; bt.sub = sub; bt.exp = exp;
    pend_q.push_back(bt);
  endtask

  task automatic push_rand(input int n);
    logic [7:0] a, b;
    logic       cin, sub;
    for (int i = 0; i < n; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      push(a, b, cin, sub, model(a, b, cin, sub));
    end
  endtask

  // One cycle: consume/check the offered result, then offer the next pending beat.
  task automatic step();
    logic [9:0] e;
    beat_t      bt;
    @(negedge clk);
    cyc++;
    bus.out_ready = or_next;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(bus.Sum), 32'(e[7:0]));
        check("cout", 32'(bus.Cout), 32'(e[8]));
`ifdef KSA_PIPE_OVF_EN
        check("ovf", 32'(bus.Ovf), 32'(e[9]));
`endif
        out_cyc.push_back(cyc);
      end
    end
    if (pend_q.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.A        = pend_q[0].a;
      bus.B        = pend_q[0].b;
      bus.Cin      = pend_q[0].cin;
      bus.op_sub   = pend_q[0].sub;
    end else begin
      bus.in_valid = 1'b0;
      bus.A        = 8'($urandom);
      bus.B        = 8'($urandom);
      bus.Cin      = 1'($urandom);
      bus.op_sub   = 1'($urandom);
    end
    #1;
    if (bus.in_valid && bus.in_ready) begin
      bt = pend_q.pop_front();
      exp_q.push_back(bt.exp);
      acc_cyc = cyc;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (pend_q.size() != 0 || exp_q.size() != 0); i++) step();
    check(tag, 32'(pend_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.Sum), 32'd0);
    check("rst_cout", 32'(bus.Cout), 32'd0);
`ifdef KSA_PIPE_OVF_EN
    check("rst_ovf", 32'(bus.Ovf), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Add with wraparound and latency measurement
    or_next = 1'b1;
    out_cyc.delete();
    push(8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
    drain("add_drain", 10);
    check("add_count", 32'(out_cyc.size()), 32'd1);
    check("add_latency", (out_cyc.size() == 1) ? 32'(out_cyc[0] - acc_cyc) : 32'hFFFF_FFFF, 32'd3);

    // Subtract, borrow cases, and add with carry-in
    out_cyc.delete();
    push(8'h10, 8'h01, 1'b0, 1'b1, {1'b0, 1'b1, 8'h0F});
    push(8'h00, 8'h01, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFF});
    push(8'h10, 8'h01, 1'b1, 1'b1, {1'b0, 1'b1, 8'h0E});
    push(8'h12, 8'h34, 1'b1, 1'b0, {1'b0, 1'b0, 8'h47});
    drain("sub_drain", 20);
    check("sub_count", 32'(out_cyc.size()), 32'd4);

    // Streaming: 16 back-to-back beats
    out_cyc.delete();
    push_rand(16);
    drain("stream_drain", 40);
    check("stream_count", 32'(out_cyc.size()), 32'd16);
    check("stream_back_to_back", (out_cyc.size() == 16) ? 32'(out_cyc[15] - out_cyc[0]) : 32'hFFFF_FFFF, 32'd15);

    // Backpressure: fill three stages, hold, then release with simultaneous accept
    out_cyc.delete();
    or_next = 1'b0;
    push_rand(5);
    repeat (3) step();
    check("bp_accepted", 32'(exp_q.size()), 32'd3);
    step();
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_pending", 32'(pend_q.size()), 32'd2);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_sum", 32'(bus.Sum), 32'(exp_q[0][7:0]));
      check("bp_hold_cout", 32'(bus.Cout), 32'(exp_q[0][8]));
      step();
    end
    check("bp_still_pending", 32'(pend_q.size()), 32'd2);
    or_next = 1'b1;
    step();
    check("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
    check("bp_release_accept", 32'(pend_q.size()), 32'd1);
    drain("bp_drain", 20);
    check("bp_count", 32'(out_cyc.size()), 32'd5);

    // Reset with three beats in flight
    or_next = 1'b0;
    push_rand(3);
    repeat (3) step();
    @(posedge clk);
    #1;
    check("rmid_full_valid", 32'(bus.out_valid), 32'd1);
    check("rmid_full_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rmid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rmid_sum", 32'(bus.Sum), 32'd0);
    check("rmid_cout", 32'(bus.Cout), 32'd0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rmid_in_ready", 32'(bus.in_ready), 32'd1);
    or_next = 1'b1;
    out_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      check("rmid_quiet", 32'(bus.out_valid), 32'd0);
    end
    push(8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});
    drain("rmid_drain", 10);
    check("rmid_count", 32'(out_cyc.size()), 32'd1);

`ifdef KSA_PIPE_OVF_EN
    // Signed overflow
    out_cyc.delete();
    push(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
    push(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
    push(8'h40, 8'h20, 1'b0, 1'b0, {1'b0, 1'b0, 8'h60});
    drain("ovf_drain", 20);
    check("ovf_count", 32'(out_cyc.size()), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
